// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped MESI L1 data cache.
//   block_state_t : per-line MESI state
//   bus_cmd_t     : snooping-bus command encoding
//   fsm_state_t   : controller FSM states
//   snoop_next()  : MESI transition applied to a line hit by a foreign snoop
package cache_pkg;

  typedef enum logic [1:0] {
    s_invalid,
    s_exclusive,
    s_shared,
    s_modified
  } block_state_t;

  typedef enum logic [1:0] {
    BUS_RD    = 2'd0,
    BUS_RDX   = 2'd1,
    BUS_UPGR  = 2'd2,
    WRITEBACK = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_UPGR,
    S_RESP
  } fsm_state_t;

  function automatic block_state_t snoop_next(input block_state_t s, input bus_cmd_t c);
    snoop_next = s;
    case (c)
      BUS_RD:   if (s == s_modified || s == s_exclusive) snoop_next = s_shared;
      BUS_RDX:  snoop_next = s_invalid;
      BUS_UPGR: if (s == s_shared) snoop_next = s_invalid;
      default:  ;
    endcase
  endfunction

endpackage

// File: rtl/cache_mesi_dm_line_store.sv
// Tag / state / data arrays for the direct-mapped cache.
//   c_*  : combinational read port for the core side
//   s_*  : combinational read port for the snoop side
//   w*   : synchronous line write (tag, data, state) from the controller
//   sw*  : state-only lane of the same write port, used by snoop transitions;
//          when both target the same set the line write wins (the controller
//          has already folded the snoop effect into it)
// Only the state array is reset; tags and data are don't-care while invalid.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int TAG_W      = 26,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int IDX_W      = $clog2(NUM_SETS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [IDX_W-1:0]      c_idx_i,
  output logic [TAG_W-1:0]      c_tag_o,
  output block_state_t          c_state_o,
  output logic [DATA_WIDTH-1:0] c_data_o,
  input  logic [IDX_W-1:0]      s_idx_i,
  output logic [TAG_W-1:0]      s_tag_o,
  output block_state_t          s_state_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      w_idx_i,
  input  logic [TAG_W-1:0]      w_tag_i,
  input  block_state_t          w_state_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic                  swe_i,
  input  logic [IDX_W-1:0]      sw_idx_i,
  input  block_state_t          sw_state_i
);

  logic [TAG_W-1:0]      tag_q   [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS];
  block_state_t          state_q [NUM_SETS];

  assign c_tag_o   = tag_q[c_idx_i];
  assign c_state_o = state_q[c_idx_i];
  assign c_data_o  = data_q[c_idx_i];
  assign s_tag_o   = tag_q[s_idx_i];
  assign s_state_o = state_q[s_idx_i];
  assign s_data_o  = data_q[s_idx_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SETS; i++) state_q[i] <= s_invalid;
    end else begin
      if (swe_i && !(we_i && sw_idx_i == w_idx_i)) state_q[sw_idx_i] <= sw_state_i;
      if (we_i) state_q[w_idx_i] <= w_state_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[w_idx_i]  <= w_tag_i;
      data_q[w_idx_i] <= w_data_i;
    end
  end

endmodule

// File: rtl/cache_mesi_dm.sv
// Direct-mapped, write-back, write-allocate L1 D-cache with MESI snooping.
// One word per block.
//   core_*  : valid/ready request in, one-cycle rvalid completion out
//   bus_*   : registered request held until the one-cycle ack
//   snoop_* : foreign bus traffic in, registered one-cycle response out
// Snoops are applied every cycle; a same-cycle core lookup sees the
// post-snoop line state.
module cache_mesi_dm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    core_valid_i,
  output logic                    core_ready_o,
  input  logic                    core_we_i,
  input  logic [DATA_WIDTH/8-1:0] core_be_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic                    core_rvalid_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    bus_req_o,
  output logic [1:0]              bus_cmd_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic                    bus_ack_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_shared_i,
  input  logic                    snoop_valid_i,
  input  logic [1:0]              snoop_cmd_i,
  input  logic [ADDR_WIDTH-1:0]   snoop_addr_i,
  output logic                    snoop_hit_o,
  output logic                    snoop_dirty_o,
  output logic [DATA_WIDTH-1:0]   snoop_data_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W    = $clog2(BE_WIDTH);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - IDX_W - OFF_W;
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(BE_WIDTH - 1);

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1 -: TAG_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [BE_WIDTH-1:0]   be);
    merge = old_w;
    for (int b = 0; b < BE_WIDTH; b++)
      if (be[b]) merge[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  // latched request (address kept word-aligned)
  fsm_state_t              state_q, state_d;
  logic                    we_q, we_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  // bus request registers
  logic                    bus_req_q, bus_req_d;
  bus_cmd_t                bus_cmd_q, bus_cmd_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  // snoop response registers
  logic                    sn_hit_q, sn_dirty_q;
  logic [DATA_WIDTH-1:0]   sn_data_q;

  // line store ports
  logic [IDX_W-1:0]      c_idx, s_idx, lw_idx;
  logic [TAG_W-1:0]      c_tag, s_tag, lw_tag;
  block_state_t          c_state, s_state, lw_state;
  logic [DATA_WIDTH-1:0] c_data, s_data, lw_data;
  logic                  lwe, swe;

  logic [ADDR_WIDTH-1:0] core_aaddr, sn_aaddr, cur_addr;
  bus_cmd_t              sn_cmd;
  block_state_t          sn_next, eff_state;
  logic                  sn_hit, sn_dirty, c_hit;

  cache_line_store #(
    .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH), .NUM_SETS(NUM_SETS), .IDX_W(IDX_W)
  ) u_store (
    .clk_i(clk_i), .reset_i(reset_i),
    .c_idx_i(c_idx), .c_tag_o(c_tag), .c_state_o(c_state), .c_data_o(c_data),
    .s_idx_i(s_idx), .s_tag_o(s_tag), .s_state_o(s_state), .s_data_o(s_data),
    .we_i(lwe), .w_idx_i(lw_idx), .w_tag_i(lw_tag), .w_state_i(lw_state), .w_data_i(lw_data),
    .swe_i(swe), .sw_idx_i(s_idx), .sw_state_i(sn_next)
  );

  // snoop side
  assign sn_aaddr = snoop_addr_i & AMASK;
  assign sn_cmd   = bus_cmd_t'(snoop_cmd_i);
  assign s_idx    = idx_of(sn_aaddr);
  assign sn_hit   = snoop_valid_i && sn_cmd != WRITEBACK && s_state != s_invalid &&
                    s_tag == tag_of(sn_aaddr);
  assign sn_next  = snoop_next(s_state, sn_cmd);
  assign sn_dirty = sn_hit && s_state == s_modified && sn_cmd != BUS_UPGR;
  assign swe      = sn_hit && sn_next != s_state;

  // core side: in IDLE look up the incoming request, otherwise the latched one
  assign core_aaddr = core_addr_i & AMASK;
  assign cur_addr   = (state_q == S_IDLE) ? core_aaddr : addr_q;
  assign c_idx      = idx_of(cur_addr);
  // snoop applies first: a same-set snoop hit overrides the stored state
  assign eff_state  = (sn_hit && s_idx == c_idx) ? sn_next : c_state;
  assign c_hit      = eff_state != s_invalid && c_tag == tag_of(cur_addr);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bus_req_d   = bus_req_q;
    bus_cmd_d   = bus_cmd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    lwe         = 1'b0;
    lw_idx      = c_idx;
    lw_tag      = c_tag;
    lw_data     = c_data;
    lw_state    = c_state;
    case (state_q)
      S_IDLE: if (core_valid_i) begin
        we_d    = core_we_i;
        be_d    = core_be_i;
        addr_d  = core_aaddr;
        wdata_d = core_wdata_i;
        if (c_hit && !core_we_i) begin
          state_d = S_RESP;
        end else if (c_hit && eff_state != s_shared) begin
          lwe      = 1'b1;
          lw_data  = merge(c_data, core_wdata_i, core_be_i);
          lw_state = s_modified;
          state_d  = S_RESP;
        end else if (c_hit) begin
          state_d    = S_UPGR;
          bus_req_d  = 1'b1;
          bus_cmd_d  = BUS_UPGR;
          bus_addr_d = core_aaddr;
        end else if (eff_state == s_modified) begin
          state_d     = S_WB;
          bus_req_d   = 1'b1;
          bus_cmd_d   = WRITEBACK;
          bus_addr_d  = ADDR_WIDTH'({c_tag, c_idx}) << OFF_W;
          bus_wdata_d = c_data;
        end else begin
          state_d    = S_FILL;
          bus_req_d  = 1'b1;
          bus_cmd_d  = core_we_i ? BUS_RDX : BUS_RD;
          bus_addr_d = core_aaddr;
        end
      end
      S_WB: if (bus_ack_i) begin
        lwe       = 1'b1;
        lw_state  = s_invalid;
        bus_req_d = 1'b0;
        state_d   = S_FILL;
      end
      S_FILL: begin
        // arriving from WB/UPGR the request was dropped on the ack; reissue
        if (!bus_req_q) begin
          bus_req_d  = 1'b1;
          bus_cmd_d  = we_q ? BUS_RDX : BUS_RD;
          bus_addr_d = addr_q;
        end else if (bus_ack_i) begin
          lwe       = 1'b1;
          lw_tag    = tag_of(addr_q);
          lw_data   = we_q ? merge(bus_rdata_i, wdata_q, be_q) : bus_rdata_i;
          lw_state  = we_q ? s_modified : (bus_shared_i ? s_shared : s_exclusive);
          bus_req_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_UPGR: if (bus_ack_i) begin
        bus_req_d = 1'b0;
        if (c_state == s_shared && c_tag == tag_of(addr_q)) begin
          lwe      = 1'b1;
          lw_data  = merge(c_data, wdata_q, be_q);
          lw_state = s_modified;
          state_d  = S_RESP;
        end else begin
          state_d = S_FILL;  // lost the line to a snoop while waiting
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_cmd_q   <= BUS_RD;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      sn_hit_q    <= 1'b0;
      sn_dirty_q  <= 1'b0;
      sn_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_req_q   <= bus_req_d;
      bus_cmd_q   <= bus_cmd_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      sn_hit_q    <= sn_hit;
      sn_dirty_q  <= sn_dirty;
      sn_data_q   <= sn_dirty ? s_data : '0;
    end
  end

  assign core_ready_o  = state_q == S_IDLE;
  assign core_rvalid_o = state_q == S_RESP;
  assign core_rdata_o  = (state_q == S_RESP) ? c_data : '0;
  assign bus_req_o     = bus_req_q;
  assign bus_cmd_o     = bus_cmd_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign snoop_hit_o   = sn_hit_q;
  assign snoop_dirty_o = sn_dirty_q;
  assign snoop_data_o  = sn_data_q;

endmodule

// File: tb/tb_cache_mesi_dm.sv
// Directed bench for cache_mesi_dm (32-bit address/data, 16 sets).
// A table of core accesses with hand-computed bus traffic and load data is
// replayed through a simple bus responder; snoop responses, the upgrade race
// and mid-transaction reset are covered by short hand-written sequences.
module tb_cache_mesi_dm;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_ready, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_rvalid;
  logic        bus_req, bus_ack, bus_shared;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        snoop_valid, snoop_hit, snoop_dirty;
  logic [1:0]  snoop_cmd;
  logic [31:0] snoop_addr, snoop_data;

  always #5 clk = ~clk;

  cache_mesi_dm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(16)) dut (
    .clk_i(clk), .reset_i(reset),
    .core_valid_i(core_valid), .core_ready_o(core_ready), .core_we_i(core_we),
    .core_be_i(core_be), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .bus_req_o(bus_req), .bus_cmd_o(bus_cmd), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .bus_shared_i(bus_shared),
    .snoop_valid_i(snoop_valid), .snoop_cmd_i(snoop_cmd), .snoop_addr_i(snoop_addr),
    .snoop_hit_o(snoop_hit), .snoop_dirty_o(snoop_dirty), .snoop_data_o(snoop_data)
  );

  int nchk = 0, nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // snp: 0 none, 1 snoop in the accept cycle, 2 snoop while first bus txn waits
  typedef struct {
    string       nm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, fill;
    bit          shr;
    int          snp;
    logic [1:0]  scmd;
    int          ntx;
    logic [1:0]  c0;
    logic [31:0] a0, w0;
    logic [1:0]  c1;
    logic [31:0] a1;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(string nm, bit we, logic [3:0] be, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] fill, bit shr, int snp,
                              logic [1:0] scmd, int ntx, logic [1:0] c0, logic [31:0] a0,
                              logic [31:0] w0, logic [1:0] c1, logic [31:0] a1, logic [31:0] rd);
    vec_t v;
    v.nm = nm; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.fill = fill;
    v.shr = shr; v.snp = snp; v.scmd = scmd; v.ntx = ntx; v.c0 = c0; v.a0 = a0;
    v.w0 = w0; v.c1 = c1; v.a1 = a1; v.rd = rd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [1:0]  cmd [2];
    logic [31:0] ad [2], wd [2];
    int cyc, wcnt, ntx, lat;
    bit stable, done;
    logic [31:0] rd;
    ntx = 0; wcnt = 0; stable = 1; done = 0; rd = '0; lat = 0;
    cmd[0] = '0; cmd[1] = '0; ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    @(negedge clk);
    core_valid = 1; core_we = v.we; core_be = v.be; core_addr = v.addr; core_wdata = v.wdata;
    if (v.snp == 1) begin snoop_valid = 1; snoop_cmd = v.scmd; snoop_addr = v.addr; end
    @(negedge clk);
    core_valid = 0; snoop_valid = 0; cyc = 1;
    while (!done && cyc < 80) begin
      bus_ack = 0; snoop_valid = 0;
      if (core_rvalid) begin
        done = 1; rd = core_rdata; lat = cyc;
      end else if (bus_req) begin
        if (wcnt == 0) begin
          if (ntx < 2) begin cmd[ntx] = bus_cmd; ad[ntx] = bus_addr; wd[ntx] = bus_wdata; end
        end else if (ntx < 2 && (bus_cmd !== cmd[ntx] || bus_addr !== ad[ntx] ||
                                 bus_wdata !== wd[ntx])) begin
          stable = 0;
        end
        if (v.snp == 2 && ntx == 0 && wcnt == 1) begin
          snoop_valid = 1; snoop_cmd = v.scmd; snoop_addr = v.addr & ~32'h3;
        end
        wcnt++;
        if (wcnt == 3) begin
          bus_ack = 1; bus_rdata = v.fill; bus_shared = v.shr; ntx++; wcnt = 0;
        end
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    bus_ack = 0; bus_shared = 0; bus_rdata = '0;
    chk({v.nm, "_done"}, 32'(done), 32'd1);
    chk({v.nm, "_ntx"}, ntx, v.ntx);
    chk({v.nm, "_rdata"}, rd, v.rd);
    chk({v.nm, "_stable"}, 32'(stable), 32'd1);
    if (v.ntx == 0) chk({v.nm, "_lat"}, lat, 1);
    if (v.ntx >= 1) begin
      chk({v.nm, "_cmd0"}, 32'(cmd[0]), 32'(v.c0));
      chk({v.nm, "_addr0"}, ad[0], v.a0);
      if (v.c0 == WRITEBACK) chk({v.nm, "_wdata0"}, wd[0], v.w0);
    end
    if (v.ntx >= 2) begin
      chk({v.nm, "_cmd1"}, 32'(cmd[1]), 32'(v.c1));
      chk({v.nm, "_addr1"}, ad[1], v.a1);
    end
  endtask

  task automatic snoop(input string nm, input logic [1:0] c, input logic [31:0] a,
                       input bit ehit, input bit edirty, input logic [31:0] edata);
    @(negedge clk);
    snoop_valid = 1; snoop_cmd = c; snoop_addr = a;
    @(negedge clk);
    snoop_valid = 0;
    chk({nm, "_hit"}, 32'(snoop_hit), 32'(ehit));
    chk({nm, "_dirty"}, 32'(snoop_dirty), 32'(edirty));
    chk({nm, "_data"}, snoop_data, edata);
    @(negedge clk);
    chk({nm, "_pulse"}, {snoop_hit, snoop_dirty, snoop_data[29:0]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk("ld_miss",       0, 4'hF, 32'h40,  32'h0,        32'hDEADBEEF, 0, 0, BUS_RD,   1, BUS_RD,    32'h40,  32'h0,        BUS_RD, 32'h0,   32'hDEADBEEF);
    tbl[1]  = mk("ld_hit",        0, 4'hF, 32'h40,  32'h0,        32'h0,        0, 0, BUS_RD,   0, BUS_RD,    32'h0,   32'h0,        BUS_RD, 32'h0,   32'hDEADBEEF);
    tbl[2]  = mk("st_hit_e",      1, 4'h3, 32'h40,  32'h12345678, 32'h0,        0, 0, BUS_RD,   0, BUS_RD,    32'h0,   32'h0,        BUS_RD, 32'h0,   32'hDEAD5678);
    tbl[3]  = mk("ld_evict_m",    0, 4'hF, 32'h440, 32'h0,        32'h11112222, 1, 0, BUS_RD,   2, WRITEBACK, 32'h40,  32'hDEAD5678, BUS_RD, 32'h440, 32'h11112222);
    tbl[4]  = mk("st_upgr",       1, 4'hC, 32'h440, 32'hAABBCCDD, 32'h0,        0, 0, BUS_RD,   1, BUS_UPGR,  32'h440, 32'h0,        BUS_RD, 32'h0,   32'hAABB2222);
    tbl[5]  = mk("ld_miss_set1",  0, 4'hF, 32'h444, 32'h0,        32'h00000001, 0, 0, BUS_RD,   1, BUS_RD,    32'h444, 32'h0,        BUS_RD, 32'h0,   32'h00000001);
    tbl[6]  = mk("ld_evict_e",    0, 4'hF, 32'h44,  32'h0,        32'h00000055, 1, 0, BUS_RD,   1, BUS_RD,    32'h44,  32'h0,        BUS_RD, 32'h0,   32'h00000055);
    tbl[7]  = mk("st_miss",       1, 4'hF, 32'h448, 32'hCAFEF00D, 32'h0,        0, 0, BUS_RD,   1, BUS_RDX,   32'h448, 32'h0,        BUS_RD, 32'h0,   32'hCAFEF00D);
    tbl[8]  = mk("st_unalign_s",  1, 4'h1, 32'h47,  32'h00000099, 32'h0,        0, 0, BUS_RD,   1, BUS_UPGR,  32'h44,  32'h0,        BUS_RD, 32'h0,   32'h00000099);
    tbl[9]  = mk("st_be0",        1, 4'h0, 32'h44,  32'hFFFFFFFF, 32'h0,        0, 0, BUS_RD,   0, BUS_RD,    32'h0,   32'h0,        BUS_RD, 32'h0,   32'h00000099);
    tbl[10] = mk("ld_unalign_ev", 0, 4'hF, 32'h446, 32'h0,        32'h00000077, 0, 0, BUS_RD,   2, WRITEBACK, 32'h44,  32'h00000099, BUS_RD, 32'h444, 32'h00000077);
    tbl[11] = mk("ld_after_inv",  0, 4'hF, 32'h448, 32'h0,        32'h0BADF00D, 0, 0, BUS_RD,   1, BUS_RD,    32'h448, 32'h0,        BUS_RD, 32'h0,   32'h0BADF00D);
    tbl[12] = mk("ld_fill_s",     0, 4'hF, 32'h4C,  32'h0,        32'h10203040, 1, 0, BUS_RD,   1, BUS_RD,    32'h4C,  32'h0,        BUS_RD, 32'h0,   32'h10203040);
    tbl[13] = mk("st_upgr_race",  1, 4'h3, 32'h4C,  32'h0000ABCD, 32'h50607080, 0, 2, BUS_UPGR, 2, BUS_UPGR,  32'h4C,  32'h0,        BUS_RDX, 32'h4C, 32'h5060ABCD);
    tbl[14] = mk("ld_fill_e",     0, 4'hF, 32'h50,  32'h0,        32'h00000001, 0, 0, BUS_RD,   1, BUS_RD,    32'h50,  32'h0,        BUS_RD, 32'h0,   32'h00000001);
    tbl[15] = mk("st_snoop_same", 1, 4'hF, 32'h50,  32'h00000002, 32'h00000003, 0, 1, BUS_RDX,  1, BUS_RDX,   32'h50,  32'h0,        BUS_RD, 32'h0,   32'h00000002);
    tbl[16] = mk("ld_post_rst",   0, 4'hF, 32'h440, 32'h0,        32'h12121212, 0, 0, BUS_RD,   1, BUS_RD,    32'h440, 32'h0,        BUS_RD, 32'h0,   32'h12121212);
    tbl[17] = mk("ld_post_rst2",  0, 4'hF, 32'h98,  32'h0,        32'h00000034, 0, 0, BUS_RD,   1, BUS_RD,    32'h98,  32'h0,        BUS_RD, 32'h0,   32'h00000034);

    reset = 1; core_valid = 0; core_we = 0; core_be = '0; core_addr = '0; core_wdata = '0;
    bus_ack = 0; bus_rdata = '0; bus_shared = 0;
    snoop_valid = 0; snoop_cmd = '0; snoop_addr = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(core_ready), 32'd1);
    chk("rst_outs", {core_rvalid, bus_req, snoop_hit, snoop_dirty, bus_cmd}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_baddr", bus_addr, 32'd0);
    chk("rst_sdata", snoop_data, 32'd0);

    for (int i = 0; i <= 10; i++) run_vec(tbl[i]);

    // 0x448 is M with CAFEF00D: BusRd supplies and demotes, BusRdX invalidates
    snoop("sn_rd_m",   BUS_RD,  32'h448,  1, 1, 32'hCAFEF00D);
    snoop("sn_rdx_s",  BUS_RDX, 32'h448,  1, 0, 32'h0);
    snoop("sn_miss",   BUS_RD,  32'h1000, 0, 0, 32'h0);
    snoop("sn_wb_ign", WRITEBACK, 32'h440, 0, 0, 32'h0);

    for (int i = 11; i <= 15; i++) run_vec(tbl[i]);

    // line 0x4C must be M after the upgrade race
    snoop("sn_rd_race", BUS_RD, 32'h4C, 1, 1, 32'h5060ABCD);

    // reset while a fill is outstanding
    @(negedge clk);
    core_valid = 1; core_we = 0; core_be = 4'hF; core_addr = 32'h98;
    @(negedge clk);
    core_valid = 0;
    begin
      int w;
      w = 0;
      while (!bus_req && w < 20) begin @(negedge clk); w++; end
      chk("rstmid_req_seen", 32'(bus_req), 32'd1);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rstmid_req", 32'(bus_req), 32'd0);
    chk("rstmid_ready", 32'(core_ready), 32'd1);
    chk("rstmid_rvalid", 32'(core_rvalid), 32'd0);

    for (int i = 16; i <= 17; i++) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
    $finish;
  end

endmodule
